// File: rtl/bus_fifo_responder_pkg.sv
// rtl/bus_fifo_responder_pkg.sv - shared register map constants for bus_fifo_responder
//
// Purpose : register offsets (addr[3:2]), STATUS/CTRL/IRQ_EN bit positions and
//           a helper that packs the STATUS word.
// Ports   : none (package).
// Macro   : BUS_FIFO_RESPONDER_IRQ_EN gives register 3 its IRQ_EN meaning.

package bus_fifo_responder_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_IRQ_EN = 2'd3
   } reg_sel_e;

   // STATUS bit positions
   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_FULL   = 2;
   localparam int ST_RX_EMPTY  = 3;
   localparam int ST_OVF       = 4;
   localparam int ST_UDF       = 5;
   localparam int ST_TX_CNT_LO = 8;
   localparam int ST_RX_CNT_LO = 16;

   // CTRL action bits (self-clearing, write-only)
   localparam int CTRL_CLR_FLAGS = 0;
   localparam int CTRL_FLUSH     = 1;
   localparam int CTRL_RX_POP    = 2;

   // IRQ_EN bits, matching the source vector {ovf|udf, tx_empty, !rx_empty}
   localparam int IRQ_RX_AVAIL = 0;
   localparam int IRQ_TX_EMPTY = 1;
   localparam int IRQ_ERR      = 2;
   localparam int IRQ_EN_W     = 3;

   function automatic logic [31:0] status_word(
      input logic       tx_full,
      input logic       tx_empty,
      input logic       rx_full,
      input logic       rx_empty,
      input logic       ovf,
      input logic       udf,
      input logic [7:0] tx_cnt,
      input logic [7:0] rx_cnt
   );
      logic [31:0] w;
      w                            = '0;
      w[ST_TX_FULL]                = tx_full;
      w[ST_TX_EMPTY]               = tx_empty;
      w[ST_RX_FULL]                = rx_full;
      w[ST_RX_EMPTY]               = rx_empty;
      w[ST_OVF]                    = ovf;
      w[ST_UDF]                    = udf;
      w[ST_TX_CNT_LO +: 8]         = tx_cnt;
      w[ST_RX_CNT_LO +: 8]         = rx_cnt;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and look-ahead count
//
// Purpose : DEPTH x WIDTH FIFO (DEPTH a power of two, >= 2). Full/empty are
//           judged on the pre-edge count, so a push while full is refused even
//           when a pop happens in the same cycle. Flush wins over push and pop.
// Ports   : clk, rst (sync, active-high)
//           push/wdata  write side; accepted when !full and !flush
//           pop         read side; accepted when !empty and !flush
//           flush       empties the FIFO at this edge
//           rdata       head entry (valid when !empty)
//           full, empty, count  current state
//           count_next  count after the coming edge (ignores rst)

module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   count_next
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push & ~full & ~flush;
      do_pop   = pop & ~empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata      = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/bus_fifo_responder.sv
// rtl/bus_fifo_responder.sv - zero-wait-state CPU bus peripheral bridging to TX/RX stream FIFOs
//
// Purpose : answers CPU loads/stores in the same cycle; DATA writes feed the
//           TX FIFO, DATA reads return the RX head; STATUS/CTRL manage both.
// Ports   : clk, rst (sync, active-high)
//           addr[31:0] (addr[3:2] decoded), cs, wr_rd (1=write), data_bus_write
//           data_bus_read  combinational read data, 0 when cs = 0
//           tx_data/tx_valid/tx_ready  device-side TX stream (out)
//           rx_data/rx_valid/rx_ready  device-side RX stream (in)
//           irq  registered interrupt (only with BUS_FIFO_RESPONDER_IRQ_EN)
// Macro   : BUS_FIFO_RESPONDER_IRQ_EN adds irq and the IRQ_EN register at offset 3.

module bus_fifo_responder
   import bus_fifo_responder_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        cs,
   input  logic        wr_rd,
   input  logic [31:0] data_bus_write,
   output logic [31:0] data_bus_read,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;

   reg_sel_e         sel;
   logic             we;
   logic             wr_data, wr_ctrl;
   logic             ctrl_clr, ctrl_flush, ctrl_pop;

   logic             tx_push, tx_pop, tx_full, tx_empty;
   logic             rx_push, rx_full, rx_empty;
   logic [31:0]      rx_head;
   logic [TX_CW-1:0] tx_count, tx_count_next;
   logic [RX_CW-1:0] rx_count, rx_count_next;

   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic [31:0]      status;

   logic             unused_ok;
   assign unused_ok = ^{addr[31:4], addr[1:0], data_bus_write[31:3]};

   // Bus decode: only stores have side effects.
   always_comb begin
      sel        = reg_sel_e'(addr[3:2]);
      we         = cs & wr_rd;
      wr_data    = we & (sel == REG_DATA);
      wr_ctrl    = we & (sel == REG_CTRL);
      ctrl_clr   = wr_ctrl & data_bus_write[CTRL_CLR_FLAGS];
      ctrl_flush = wr_ctrl & data_bus_write[CTRL_FLUSH];
      ctrl_pop   = wr_ctrl & data_bus_write[CTRL_RX_POP];
      tx_push    = wr_data;
      tx_pop     = tx_valid & tx_ready;
      rx_push    = rx_valid & rx_ready;
   end

   sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(32)) u_tx_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (tx_push),
      .pop        (tx_pop),
      .flush      (ctrl_flush),
      .wdata      (data_bus_write),
      .rdata      (tx_data),
      .full       (tx_full),
      .empty      (tx_empty),
      .count      (tx_count),
      .count_next (tx_count_next)
   );

   sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(32)) u_rx_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (rx_push),
      .pop        (ctrl_pop),
      .flush      (ctrl_flush),
      .wdata      (rx_data),
      .rdata      (rx_head),
      .full       (rx_full),
      .empty      (rx_empty),
      .count      (rx_count),
      .count_next (rx_count_next)
   );

   assign tx_valid = ~tx_empty;
   assign rx_ready = ~rx_full;

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   // A pop alongside a flush is not an underflow.
   always_comb begin
      ovf_d = (ovf_q & ~ctrl_clr) | (tx_push & tx_full);
      udf_d = (udf_q & ~ctrl_clr) | (ctrl_pop & rx_empty & ~ctrl_flush);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

`ifdef BUS_FIFO_RESPONDER_IRQ_EN
   logic [IRQ_EN_W-1:0] irq_en_q, irq_en_d;
   logic                irq_q, irq_d;
   logic [IRQ_EN_W-1:0] irq_src_next;

   // irq is registered from the state the FIFOs and flags reach at this edge.
   always_comb begin
      irq_en_d = irq_en_q;
      if (we & (sel == REG_IRQ_EN)) irq_en_d = data_bus_write[IRQ_EN_W-1:0];
      irq_src_next               = '0;
      irq_src_next[IRQ_ERR]      = ovf_d | udf_d;
      irq_src_next[IRQ_TX_EMPTY] = (tx_count_next == '0);
      irq_src_next[IRQ_RX_AVAIL] = (rx_count_next != '0);
      irq_d = |(irq_en_d & irq_src_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   logic unused_next;
   assign unused_next = ^{tx_count_next, rx_count_next};
`endif

   always_comb begin
      status = status_word(tx_full, tx_empty, rx_full, rx_empty, ovf_q, udf_q,
                           8'(tx_count), 8'(rx_count));
   end

   always_comb begin
      data_bus_read = '0;
      if (cs) begin
         case (sel)
            REG_DATA:   data_bus_read = rx_empty ? 32'h0 : rx_head;
            REG_STATUS: data_bus_read = status;
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
            REG_IRQ_EN: data_bus_read = {{(32-IRQ_EN_W){1'b0}}, irq_en_q};
`endif
            default:    data_bus_read = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_fifo_responder.sv
// tb/tb_bus_fifo_responder.sv - self-checking bench for bus_fifo_responder

module tb_bus_fifo_responder;

   localparam int TXD = 4;
   localparam int RXD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        cs = 1'b0;
   logic        wr_rd = 1'b0;
   logic [31:0] data_bus_write = '0;
   logic [31:0] data_bus_read;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
   logic        irq;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] tx_m[$];
   logic [31:0] rx_m[$];
   logic        ovf_m, udf_m, irq_m;
   logic [2:0]  irq_en_m;

   always #5 clk = ~clk;

   bus_fifo_responder #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk            (clk),
      .rst            (rst),
      .addr           (addr),
      .cs             (cs),
      .wr_rd          (wr_rd),
      .data_bus_write (data_bus_write),
      .data_bus_read  (data_bus_read),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready)
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
      ,
      .irq            (irq)
`endif
   );

   // Bus drivers; called at edge+1, return at edge+1.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; data_bus_write = d; cs = 1'b1; wr_rd = 1'b1;
      @(posedge clk); #1;
      cs = 1'b0; wr_rd = 1'b0; data_bus_write = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; cs = 1'b1; wr_rd = 1'b0;
      #1;
      d = data_bus_read;
      cs = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cs = 1'b0; wr_rd = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tx_m.delete(); rx_m.delete();
      ovf_m = 1'b0; udf_m = 1'b0; irq_m = 1'b0; irq_en_m = '0;
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = (tx_m.size() == TXD);
      s[1] = (tx_m.size() == 0);
      s[2] = (rx_m.size() == RXD);
      s[3] = (rx_m.size() == 0);
      s[4] = ovf_m;
      s[5] = udf_m;
      s[15:8]  = 8'(tx_m.size());
      s[23:16] = 8'(rx_m.size());
      return s;
   endfunction

   function automatic logic [31:0] model_read(input logic c, input logic [1:0] r);
      if (!c) return 32'h0;
      case (r)
         2'd0: return (rx_m.size() == 0) ? 32'h0 : rx_m[0];
         2'd1: return model_status();
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
         2'd3: return {29'h0, irq_en_m};
`endif
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one edge using the pre-edge state and given inputs.
   task automatic model_step(input logic c, input logic w, input logic [1:0] r,
                             input logic [31:0] d, input logic trdy,
                             input logic rvld, input logic [31:0] rdat);
      bit we, flush, clr, pop, push, txpop, rxpush, new_ovf, new_udf;
      we      = c && w;
      flush   = we && r == 2 && d[1];
      clr     = we && r == 2 && d[0];
      pop     = we && r == 2 && d[2];
      push    = we && r == 0;
      txpop   = tx_m.size() != 0 && trdy;
      rxpush  = rvld && rx_m.size() < RXD;
      new_ovf = push && tx_m.size() == TXD;
      new_udf = pop && rx_m.size() == 0 && !flush;
      if (flush) begin
         tx_m.delete();
         rx_m.delete();
      end else begin
         if (txpop) void'(tx_m.pop_front());
         if (push && !new_ovf) tx_m.push_back(d);
         if (pop && rx_m.size() != 0) void'(rx_m.pop_front());
         if (rxpush) rx_m.push_back(rdat);
      end
      ovf_m = (ovf_m && !clr) || new_ovf;
      udf_m = (udf_m && !clr) || new_udf;
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
      if (we && r == 3) irq_en_m = d[2:0];
`endif
      irq_m = (irq_en_m[2] && (ovf_m || udf_m)) || (irq_en_m[1] && tx_m.size() == 0)
              || (irq_en_m[0] && rx_m.size() != 0);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL reset_status: got %h want %h", v, 32'h0000000A); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
   endtask

   task automatic test_tx_overflow();
      logic [31:0] v;
      logic [31:0] vals [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      tx_ready = 1'b0;
      foreach (vals[i]) bus_write(32'h0, vals[i]);
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h00000419) begin n_err++; $display("FAIL tx_full_status: got %h want %h", v, 32'h00000419); end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (tx_valid !== 1'b1 || tx_data !== vals[i]) begin
            n_err++; $display("FAIL tx_drain_%0d: got valid=%b data=%h want 1 %h", i, tx_valid, tx_data, vals[i]);
         end
         @(posedge clk); #1;
      end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained_valid: got %b want 0", tx_valid); end
      tx_ready = 1'b0;
      bus_write(32'h8, 32'h1);
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL ovf_clear: got %h want %h", v, 32'h0000000A); end
   endtask

   task automatic test_rx_pop_udf();
      logic [31:0] v;
      rx_data = 32'hA5A5; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_read(32'h0, v);
         n_cmp++; if (v !== 32'hA5A5) begin n_err++; $display("FAIL rx_peek_%0d: got %h want %h", i, v, 32'hA5A5); end
         @(posedge clk); #1;
      end
      bus_write(32'h8, 32'h4);
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL rx_pop_status: got %h want %h", v, 32'h0000000A); end
      bus_read(32'h0, v);
      n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rx_empty_read: got %h want 0", v); end
      bus_write(32'h8, 32'h4);
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000002A) begin n_err++; $display("FAIL udf_set: got %h want %h", v, 32'h0000002A); end
      bus_write(32'h8, 32'h1);
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL udf_clear: got %h want %h", v, 32'h0000000A); end
   endtask

   task automatic test_cs_idle();
      logic [31:0] v;
      addr = 32'h0; wr_rd = 1'b1; cs = 1'b0; data_bus_write = 32'h77;
      #1;
      n_cmp++; if (data_bus_read !== 32'h0) begin n_err++; $display("FAIL cs0_read: got %h want 0", data_bus_read); end
      @(posedge clk); #1;
      wr_rd = 1'b0;
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL cs0_no_push: got %b want 0", tx_valid); end
      addr = 32'h4; #1;
      n_cmp++; if (data_bus_read !== 32'h0) begin n_err++; $display("FAIL cs0_status_read: got %h want 0", data_bus_read); end
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL cs0_status: got %h want %h", v, 32'h0000000A); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [31:0] expq [3] = '{32'h61, 32'h62, 32'h63};
      tx_ready = 1'b0;
      bus_write(32'h0, 32'h61);
      bus_write(32'h0, 32'h62);
      tx_ready = 1'b1;
      #1;
      n_cmp++; if (tx_data !== 32'h61) begin n_err++; $display("FAIL b2b_head: got %h want %h", tx_data, 32'h61); end
      bus_write(32'h0, 32'h63);
      tx_ready = 1'b0;
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h00000208) begin n_err++; $display("FAIL b2b_count: got %h want %h", v, 32'h00000208); end
      tx_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         #1;
         n_cmp++; if (tx_valid !== 1'b1 || tx_data !== expq[i]) begin
            n_err++; $display("FAIL b2b_order_%0d: got valid=%b data=%h want 1 %h", i, tx_valid, tx_data, expq[i]);
         end
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", tx_valid); end
   endtask

   task automatic test_flush();
      logic [31:0] v;
      rx_data = 32'hB1; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      bus_write(32'h0, 32'h99);
      rx_data = 32'hC2; rx_valid = 1'b1;
      addr = 32'h8; data_bus_write = 32'h2; cs = 1'b1; wr_rd = 1'b1;
      #1;
      n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL flush_rx_ready: got %b want 1", rx_ready); end
      @(posedge clk); #1;
      cs = 1'b0; wr_rd = 1'b0; rx_valid = 1'b0;
      bus_read(32'h4, v);
      n_cmp++; if (v !== 32'h0000000A) begin n_err++; $display("FAIL flush_status: got %h want %h", v, 32'h0000000A); end
      bus_read(32'h0, v);
      n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL flush_rx_dropped: got %h want 0", v); end
   endtask

`ifdef BUS_FIFO_RESPONDER_IRQ_EN
   task automatic test_irq();
      logic [31:0] v;
      bus_write(32'h8, 32'h3);
      bus_write(32'hC, 32'h1);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_rx_idle: got %b want 0", irq); end
      rx_data = 32'hD00D; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rx_avail: got %b want 1", irq); end
      bus_write(32'h8, 32'h4);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_rx_popped: got %b want 0", irq); end
      bus_write(32'hC, 32'h4);
      bus_read(32'hC, v);
      n_cmp++; if (v !== 32'h4) begin n_err++; $display("FAIL irq_en_read: got %h want 4", v); end
      bus_write(32'h8, 32'h4);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_udf: got %b want 1", irq); end
      bus_write(32'h8, 32'h1);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b want 0", irq); end
      bus_write(32'hC, 32'h2);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
      bus_write(32'hC, 32'h0);
   endtask
`endif

   task automatic test_random();
      logic        c, w, trdy, rvld;
      logic [1:0]  r;
      logic [31:0] d, rdat, exp_rd;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         c    = ($urandom_range(0, 3) != 0);
         w    = $urandom_range(0, 1) == 1;
         r    = 2'($urandom_range(0, 3));
         d    = $urandom;
         if (r == 2) d[1] = ($urandom_range(0, 7) == 0);
         trdy = ($urandom_range(0, 2) == 0);
         rvld = $urandom_range(0, 1) == 1;
         rdat = $urandom;
         cs = c; wr_rd = w; addr = {$urandom} & 32'hFFFF_FFF0 | {28'h0, r, 2'($urandom_range(0, 3))};
         data_bus_write = d; tx_ready = trdy; rx_valid = rvld; rx_data = rdat;
         #1;
         n_cmp++; if (tx_valid !== (tx_m.size() != 0)) begin
            n_err++; $display("FAIL rnd_tx_valid @%0d: got %b want %b", i, tx_valid, tx_m.size() != 0);
         end
         if (tx_m.size() != 0) begin
            n_cmp++; if (tx_data !== tx_m[0]) begin n_err++; $display("FAIL rnd_tx_data @%0d: got %h want %h", i, tx_data, tx_m[0]); end
         end
         n_cmp++; if (rx_ready !== (rx_m.size() < RXD)) begin
            n_err++; $display("FAIL rnd_rx_ready @%0d: got %b want %b", i, rx_ready, rx_m.size() < RXD);
         end
         if (!(c && w)) begin
            exp_rd = model_read(c, r);
            n_cmp++; if (data_bus_read !== exp_rd) begin
               n_err++; $display("FAIL rnd_read @%0d: got %h want %h", i, data_bus_read, exp_rd);
            end
         end
         @(posedge clk);
         model_step(c, w, r, d, trdy, rvld, rdat);
         #1;
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
         n_cmp++; if (irq !== irq_m) begin n_err++; $display("FAIL rnd_irq @%0d: got %b want %b", i, irq, irq_m); end
`endif
      end
      cs = 1'b0; wr_rd = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
      // Mid-traffic reset must discard everything.
      do_reset();
      cs = 1'b1; addr = 32'h4; #1;
      n_cmp++; if (data_bus_read !== 32'h0000000A) begin
         n_err++; $display("FAIL rnd_post_reset: got %h want %h", data_bus_read, 32'h0000000A);
      end
      cs = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tx_overflow();
      test_rx_pop_udf();
      test_cs_idle();
      test_back_to_back();
      test_flush();
`ifdef BUS_FIFO_RESPONDER_IRQ_EN
      test_irq();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
